// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the ID-stage instruction description and the hazard controller's
// responses for the 5-stage IF/ID/EX/MEM/WB core.
//
// Parameters:
//   RF_ADDR_W - register-number width
//   CNT_W     - stall-counter width
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
//   id_rd, id_rf_we, id_is_load, br_taken            : inputs from ID
//   id_ready_go, if_stall, if_flush,
//   fwd_src1_sel, fwd_src2_sel, stall_cnt            : outputs to the pipeline
//
// Modports:
//   master - the pipeline side that drives the ID description
//   slave  - the hazard controller
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int RF_ADDR_W = 5,
    parameter int CNT_W     = 16
);
    logic                 id_valid;
    logic [RF_ADDR_W-1:0] id_rs1;
    logic [RF_ADDR_W-1:0] id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [RF_ADDR_W-1:0] id_rd;
    logic                 id_rf_we;
    logic                 id_is_load;
    logic                 br_taken;

    logic                 id_ready_go;
    logic                 if_stall;
    logic                 if_flush;
    logic [1:0]           fwd_src1_sel;
    logic [1:0]           fwd_src2_sel;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rf_we, id_is_load, br_taken,
        input  id_ready_go, if_stall, if_flush,
               fwd_src1_sel, fwd_src2_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rf_we, id_is_load, br_taken,
        output id_ready_go, if_stall, if_flush,
               fwd_src1_sel, fwd_src2_sel, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Read-after-write hazard and stall controller for the 5-stage core. A shadow
// scoreboard mirrors the destination registers in flight in EX, MEM and WB;
// the instruction sitting in ID is compared against it to decide whether it
// may advance, whether IF must hold, whether IF must be squashed on a taken
// branch, and (optionally) where each operand should be forwarded from.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   hz   - pipe_hazard_ctrl_if.slave: ID description in, control out
//
// Configuration macro:
//   HAZARD_FORWARD_EN - when defined, operand forwarding is assumed present,
//                       so only load-use stalls and the forward selects are
//                       driven. When undefined, any pending write to a source
//                       stalls until it has left WB and the selects stay 0.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int RF_ADDR_W = 5,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     v;
        reg_idx_t rd;
        logic     load;
    } sb_entry_t;

    sb_entry_t        ex_q, ex_d;
    sb_entry_t        mem_q, mem_d;
    sb_entry_t        wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       rs1_ex, rs1_mem, rs1_wb;
    logic       rs2_ex, rs2_mem, rs2_wb;
    logic       hazard;
    logic       ready_go;
    logic       stall;
    logic [1:0] sel1;
    logic [1:0] sel2;

    function automatic logic stage_match(sb_entry_t s, logic used, reg_idx_t rs);
        return used && (rs != '0) && s.v && (s.rd == rs);
    endfunction

`ifdef HAZARD_FORWARD_EN
    // A loading EX entry cannot forward yet; the caller stalls in that case,
    // so falling through to MEM/WB there is harmless.
    function automatic logic [1:0] pick_sel(logic ex_hit, logic mem_hit,
                                            logic wb_hit, logic ex_load);
        if (ex_hit && !ex_load) return 2'd1;
        else if (mem_hit)       return 2'd2;
        else if (wb_hit)        return 2'd3;
        else                    return 2'd0;
    endfunction
`endif

    // Compare both ID sources against every scoreboard stage and derive the
    // hazard, handshake and forwarding decisions for this cycle.
    always_comb begin
        rs1_ex  = stage_match(ex_q,  hz.id_rs1_used, hz.id_rs1);
        rs1_mem = stage_match(mem_q, hz.id_rs1_used, hz.id_rs1);
        rs1_wb  = stage_match(wb_q,  hz.id_rs1_used, hz.id_rs1);
        rs2_ex  = stage_match(ex_q,  hz.id_rs2_used, hz.id_rs2);
        rs2_mem = stage_match(mem_q, hz.id_rs2_used, hz.id_rs2);
        rs2_wb  = stage_match(wb_q,  hz.id_rs2_used, hz.id_rs2);

`ifdef HAZARD_FORWARD_EN
        // Load data only arrives from DRAM at the end of MEM, so the only
        // unresolvable case is a consumer directly behind its load.
        hazard = (rs1_ex | rs2_ex) & ex_q.load;
        sel1   = pick_sel(rs1_ex, rs1_mem, rs1_wb, ex_q.load);
        sel2   = pick_sel(rs2_ex, rs2_mem, rs2_wb, ex_q.load);
`else
        // No bypass paths and no regfile write-through: wait until the
        // producer has fully retired.
        hazard = rs1_ex | rs1_mem | rs1_wb | rs2_ex | rs2_mem | rs2_wb;
        sel1   = 2'd0;
        sel2   = 2'd0;
`endif

        ready_go = ~hz.id_valid | ~hazard;
        stall    = hz.id_valid & hazard;
    end

    // Next-state: the scoreboard slides one stage per cycle; EX only gets a
    // real entry when a writing instruction actually leaves ID.
    always_comb begin
        ex_d      = '0;
        mem_d     = ex_q;
        wb_d      = mem_q;
        if (hz.id_valid && ready_go && hz.id_rf_we && (hz.id_rd != '0)) begin
            ex_d.v    = 1'b1;
            ex_d.rd   = hz.id_rd;
            ex_d.load = hz.id_is_load;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers; reset empties the scoreboard so any stall in progress
    // is released on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Load flags of the older stages never influence a decision.
    logic unused_load_bits;
    assign unused_load_bits = ^{ex_q.load, mem_q.load, wb_q.load};

    assign hz.id_ready_go  = ready_go;
    assign hz.if_stall     = stall;
    assign hz.if_flush     = hz.id_valid & ready_go & hz.br_taken;
    assign hz.fwd_src1_sel = sel1;
    assign hz.fwd_src2_sel = sel2;
    assign hz.stall_cnt    = stall_cnt_q;
endmodule
